// File: rtl/ddr2_rd_btpipe_bridge_if.sv
// Stream and pipe-endpoint bundle between the MIG read path, the bridge and
// the host-side block-throttled pipe.
//
// Handshake rules:
//   - in_data moves from master to slave on every rising edge where in_valid
//     and in_ready are both high. in_ready depends only on bridge state, never
//     on in_valid.
//   - ep_read consumes one 16-bit word per high cycle. ep_datain always shows
//     the current head half-word (first-word-fall-through).
//   - ep_blockstrobe is a single-cycle pulse that opens a block. It is only
//     legal while ep_ready is high and no block is in progress.
interface ddr2_rd_btpipe_bridge_if #(
    parameter int APPDATA_WIDTH = 32
);
    logic [APPDATA_WIDTH-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     ep_read;
    logic                     ep_blockstrobe;
    logic                     ep_ready;
    logic [15:0]              ep_datain;

    modport slave (
        input  in_data, in_valid, ep_read, ep_blockstrobe,
        output in_ready, ep_ready, ep_datain
    );

    modport master (
        output in_data, in_valid, ep_read, ep_blockstrobe,
        input  in_ready, ep_ready, ep_datain
    );
endinterface

// File: rtl/ddr2_rd_btpipe_bridge.sv
// Buffers 32-bit MIG read words and serves them to the host pipe-out as
// 16-bit words, low half first, one block per block strobe. Host protocol
// violations and reads from an empty buffer raise sticky flags.
// APPDATA_WIDTH must be 32, BLOCK_WORDS even and >= 2, BUF_DEPTH a power of
// two holding at least one block.
module ddr2_rd_btpipe_bridge #(
    parameter int APPDATA_WIDTH = 32,
    parameter int BLOCK_WORDS   = 256,
    parameter int BUF_DEPTH     = 256
) (
    input  logic                          ti_clk,
    input  logic                          rst_n,
    input  logic                          flush,
    ddr2_rd_btpipe_bridge_if.slave        bus,
    output logic [31:0]                   words_sent,
    output logic                          underflow_err,
    output logic                          proto_err,
    output logic                          fsm_state
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HC_W   = CNT_W + 1;
    localparam int BLK_W  = $clog2(BLOCK_WORDS + 1);
    localparam int HALF_W = APPDATA_WIDTH / 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [APPDATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         entries;
    logic                     half_sel;
    logic [HC_W-1:0]          half_count;
    logic                     has_data;
    logic                     push;
    logic                     pop;
    logic                     pop_word;
    logic                     underflow_set;

    state_t                   state;
    state_t                   state_next;
    logic                     ep_ready_q;
    logic                     ep_ready_d;
    logic [BLK_W-1:0]         blk_cnt;
    logic [BLK_W-1:0]         blk_cnt_d;
    logic                     strobe_ok;
    logic                     proto_set;

    // Half-words still owed to the host: two per entry, minus the low half
    // already sent from the head entry.
    assign half_count    = {entries, 1'b0} - HC_W'(half_sel);
    assign has_data      = (half_count != '0);
    assign bus.in_ready  = (entries < CNT_W'(BUF_DEPTH));
    assign push          = bus.in_valid && bus.in_ready && !flush;
    assign pop           = bus.ep_read && has_data && !flush;
    assign pop_word      = pop && half_sel;
    assign underflow_set = bus.ep_read && !has_data;
    assign strobe_ok     = bus.ep_blockstrobe && (state == S_IDLE) && ep_ready_q;

    assign bus.ep_datain = !has_data ? '0 :
                           half_sel  ? mem[rd_ptr][APPDATA_WIDTH-1:HALF_W] :
                                       mem[rd_ptr][HALF_W-1:0];
    assign bus.ep_ready  = ep_ready_q;
    assign fsm_state     = (state == S_ACTIVE);

    // Buffer storage: written on every accepted push, no reset needed.
    always_ff @(posedge ti_clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Pointers, occupancy, half select and delivered-word counter.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            entries    <= '0;
            half_sel   <= 1'b0;
            words_sent <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            entries    <= '0;
            half_sel   <= 1'b0;
            words_sent <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                half_sel   <= !half_sel;
                words_sent <= words_sent + 32'd1;
                if (half_sel) rd_ptr <= rd_ptr + PTR_W'(1);
            end
            entries <= entries + CNT_W'(push) - CNT_W'(pop_word);
        end
    end

    // Block FSM state register.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n)     state <= S_IDLE;
        else if (flush) state <= S_IDLE;
        else            state <= state_next;
    end

    // Next state: a legal strobe opens a block; the read that completes the
    // block closes it unless a strobe restarts the count in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (strobe_ok) state_next = S_ACTIVE;
            S_ACTIVE: if (!bus.ep_blockstrobe && bus.ep_read &&
                          (blk_cnt == BLK_W'(BLOCK_WORDS - 1)))
                          state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM outputs: block-ready advertisement, block read count and protocol
    // error detection. A strobe is handled before a same-cycle read, so that
    // read counts as the first word of the new block.
    always_comb begin
        ep_ready_d = 1'b0;
        blk_cnt_d  = blk_cnt;
        proto_set  = 1'b0;
        case (state)
            S_IDLE: begin
                ep_ready_d = !strobe_ok && (half_count >= HC_W'(BLOCK_WORDS));
                if (bus.ep_blockstrobe && !strobe_ok) proto_set = 1'b1;
                if (bus.ep_read && !strobe_ok)        proto_set = 1'b1;
                if (strobe_ok)                        blk_cnt_d = BLK_W'(bus.ep_read);
            end
            S_ACTIVE: begin
                if (bus.ep_blockstrobe) begin
                    proto_set = 1'b1;
                    blk_cnt_d = BLK_W'(bus.ep_read);
                end else if (bus.ep_read) begin
                    blk_cnt_d = blk_cnt + BLK_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered FSM outputs and sticky error flags.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            ep_ready_q    <= 1'b0;
            blk_cnt       <= '0;
            underflow_err <= 1'b0;
            proto_err     <= 1'b0;
        end else if (flush) begin
            ep_ready_q    <= 1'b0;
            blk_cnt       <= '0;
            underflow_err <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            ep_ready_q <= ep_ready_d;
            blk_cnt    <= blk_cnt_d;
            if (underflow_set) underflow_err <= 1'b1;
            if (proto_set)     proto_err     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr2_rd_btpipe_bridge.sv
// Bench for ddr2_rd_btpipe_bridge. The reference model keeps the buffered
// data as a plain queue of 16-bit host words and the block protocol as a
// handful of flags and counters.
module tb_ddr2_rd_btpipe_bridge;
    localparam int BW    = 256;
    localparam int DEPTH = 256;

    logic        ti_clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] words_sent;
    logic        underflow_err;
    logic        proto_err;
    logic        fsm_state;

    ddr2_rd_btpipe_bridge_if #(.APPDATA_WIDTH(32)) bus ();

    ddr2_rd_btpipe_bridge #(
        .APPDATA_WIDTH(32),
        .BLOCK_WORDS  (BW),
        .BUF_DEPTH    (DEPTH)
    ) dut (
        .ti_clk       (ti_clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .words_sent   (words_sent),
        .underflow_err(underflow_err),
        .proto_err    (proto_err),
        .fsm_state    (fsm_state)
    );

    // Clock.
    initial begin
        ti_clk = 1'b0;
        forever #5 ti_clk = ~ti_clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [15:0] exp_q[$];
    bit          m_active;
    int          m_blk;
    bit          m_ready;
    logic [31:0] m_ws;
    bit          m_under;
    bit          m_proto;

    task automatic m_reset();
        exp_q.delete();
        m_active = 0;
        m_blk    = 0;
        m_ready  = 0;
        m_ws     = '0;
        m_under  = 0;
        m_proto  = 0;
    endtask

    // One clock of host/MIG activity applied to the model.
    task automatic m_step(input logic fl, input logic iv, input logic [31:0] d,
                          input logic rd, input logic sb);
        int halves;
        bit in_rdy;
        bit s_ok;
        bit was_active;
        if (fl) begin
            m_reset();
            return;
        end
        halves     = exp_q.size();
        in_rdy     = ((halves + 1) / 2) < DEPTH;
        was_active = m_active;
        s_ok       = sb && !m_active && m_ready;
        if (sb && !s_ok) m_proto = 1;
        if (rd && !m_active && !s_ok) m_proto = 1;
        if (rd) begin
            if (halves > 0) begin
                void'(exp_q.pop_front());
                m_ws = m_ws + 32'd1;
            end else begin
                m_under = 1;
            end
        end
        if (iv && in_rdy) begin
            exp_q.push_back(d[15:0]);
            exp_q.push_back(d[31:16]);
        end
        m_ready = !was_active && !s_ok && (halves >= BW);
        if (s_ok || (was_active && sb)) begin
            m_active = 1;
            m_blk    = rd ? 1 : 0;
        end else if (was_active && rd) begin
            m_blk++;
            if (m_blk == BW) m_active = 0;
        end
    endtask

    function automatic logic [15:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
    endfunction

    function automatic logic [52:0] exp_vec();
        return {1'(((exp_q.size() + 1) / 2) < DEPTH), 1'(m_ready), exp_head(),
                m_ws, 1'(m_under), 1'(m_proto), 1'(m_active)};
    endfunction

    function automatic logic [52:0] dut_vec();
        return {bus.in_ready, bus.ep_ready, bus.ep_datain, words_sent,
                underflow_err, proto_err, fsm_state};
    endfunction

    // Driver: apply inputs for one cycle, update the model, land 1ns after
    // the rising edge.
    task automatic drive_cycle(input logic fl, input logic iv, input logic [31:0] d,
                               input logic rd, input logic sb);
        flush              = fl;
        bus.in_valid       = iv;
        bus.in_data        = d;
        bus.ep_read        = rd;
        bus.ep_blockstrobe = sb;
        m_step(fl, iv, d, rd, sb);
        @(posedge ti_clk);
        #1;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.ep_read        = 1'b0;
        bus.ep_blockstrobe = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 1, $urandom, 0, 0);
    endtask

    task automatic host_reads(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 1, 0);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.ep_ready !== 1'b0) begin n_err++; $display("FAIL reset_ep_ready: got %b want 0", bus.ep_ready); end
        n_cmp++; if (bus.ep_datain !== 16'h0) begin n_err++; $display("FAIL reset_datain: got %h want 0000", bus.ep_datain); end
        n_cmp++; if (words_sent !== 32'd0) begin n_err++; $display("FAIL reset_words_sent: got %0d want 0", words_sent); end
        n_cmp++; if ({underflow_err, proto_err, fsm_state} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {underflow_err, proto_err, fsm_state}); end
    endtask

    // 128 patterned words, one block read back with fixed expected values.
    task automatic test_block(input string tag);
        logic [15:0] want;
        for (int n = 0; n < 128; n++) drive_cycle(0, 1, {16'(n + 'h100), 16'(n)}, 0, 0);
        n_cmp++; if (bus.ep_ready !== 1'b0) begin n_err++; $display("FAIL %s_ready_latency: got %b want 0", tag, bus.ep_ready); end
        drive_cycle(0, 0, '0, 0, 0);
        n_cmp++; if (bus.ep_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_rise: got %b want 1", tag, bus.ep_ready); end
        drive_cycle(0, 0, '0, 0, 1);
        n_cmp++; if ({bus.ep_ready, fsm_state} !== 2'b01) begin n_err++; $display("FAIL %s_strobe: got %b want 01", tag, {bus.ep_ready, fsm_state}); end
        for (int i = 0; i < 256; i++) begin
            want = (i % 2 == 0) ? 16'(i / 2) : 16'(i / 2 + 'h100);
            n_cmp++; if (bus.ep_datain !== want) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, bus.ep_datain, want); end
            drive_cycle(0, 0, '0, 1, 0);
        end
        n_cmp++; if (words_sent !== 32'd256) begin n_err++; $display("FAIL %s_words_sent: got %0d want 256", tag, words_sent); end
        n_cmp++; if ({bus.ep_ready, fsm_state, underflow_err, proto_err} !== 4'b0000) begin n_err++; $display("FAIL %s_end_flags: got %b want 0000", tag, {bus.ep_ready, fsm_state, underflow_err, proto_err}); end
    endtask

    task automatic test_threshold();
        push_random(127);
        drive_cycle(0, 0, '0, 0, 0);
        drive_cycle(0, 0, '0, 0, 0);
        n_cmp++; if (bus.ep_ready !== 1'b0) begin n_err++; $display("FAIL thr_127: got %b want 0", bus.ep_ready); end
        push_random(1);
        drive_cycle(0, 0, '0, 0, 0);
        n_cmp++; if (bus.ep_ready !== 1'b1) begin n_err++; $display("FAIL thr_128: got %b want 1", bus.ep_ready); end
        drive_cycle(0, 0, '0, 0, 1);
        for (int c = 0; c < 2000 && m_active; c++) begin
            n_cmp++; if (bus.ep_datain !== exp_head()) begin n_err++; $display("FAIL thr_data: got %h want %h", bus.ep_datain, exp_head()); end
            drive_cycle(0, 0, '0, 1'($urandom_range(0, 3) != 0), 0);
        end
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL thr_end: got %h want %h", dut_vec(), exp_vec()); end
        n_cmp++; if ({fsm_state, proto_err} !== 2'b00) begin n_err++; $display("FAIL thr_idle: got %b want 00", {fsm_state, proto_err}); end
    endtask

    task automatic test_full_wrap();
        drive_cycle(1, 0, '0, 0, 0);
        push_random(256);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, $urandom, 0, 0);
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_hold[%0d]: got %b want 0", i, bus.in_ready); end
        end
        drive_cycle(0, 0, '0, 0, 1);
        host_reads(2);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_release: got %b want 1", bus.in_ready); end
        push_random(1);
        for (int i = 0; i < 254; i++) begin
            n_cmp++; if (bus.ep_datain !== exp_head()) begin n_err++; $display("FAIL wrap_data_a[%0d]: got %h want %h", i, bus.ep_datain, exp_head()); end
            drive_cycle(0, 0, '0, 1, 0);
        end
        drive_cycle(0, 0, '0, 0, 0);
        n_cmp++; if (bus.ep_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready2: got %b want 1", bus.ep_ready); end
        drive_cycle(0, 0, '0, 0, 1);
        for (int i = 0; i < 258; i++) begin
            n_cmp++; if (bus.ep_datain !== exp_head()) begin n_err++; $display("FAIL wrap_data_b[%0d]: got %h want %h", i, bus.ep_datain, exp_head()); end
            drive_cycle(0, 0, '0, 1, 0);
        end
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL wrap_end: got %h want %h", dut_vec(), exp_vec()); end
        n_cmp++; if (words_sent !== 32'd514) begin n_err++; $display("FAIL wrap_words: got %0d want 514", words_sent); end
        drive_cycle(1, 0, '0, 0, 0);
    endtask

    task automatic test_underflow();
        drive_cycle(1, 0, '0, 0, 0);
        drive_cycle(0, 0, '0, 1, 0);
        n_cmp++; if (underflow_err !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b want 1", underflow_err); end
        n_cmp++; if (bus.ep_datain !== 16'h0) begin n_err++; $display("FAIL uf_datain: got %h want 0000", bus.ep_datain); end
        n_cmp++; if (words_sent !== 32'd0) begin n_err++; $display("FAIL uf_words: got %0d want 0", words_sent); end
        drive_cycle(1, 0, '0, 0, 0);
        n_cmp++; if ({underflow_err, proto_err} !== 2'b00) begin n_err++; $display("FAIL uf_flush: got %b want 00", {underflow_err, proto_err}); end
    endtask

    task automatic test_proto();
        drive_cycle(0, 0, '0, 0, 1);
        n_cmp++; if ({proto_err, fsm_state} !== 2'b10) begin n_err++; $display("FAIL proto_strobe: got %b want 10", {proto_err, fsm_state}); end
        drive_cycle(1, 0, '0, 0, 0);
        drive_cycle(0, 1, 32'hBEEF_CAFE, 0, 0);
        drive_cycle(0, 0, '0, 1, 0);
        n_cmp++; if ({proto_err, underflow_err} !== 2'b10) begin n_err++; $display("FAIL proto_idle_read: got %b want 10", {proto_err, underflow_err}); end
        n_cmp++; if ({words_sent, bus.ep_datain} !== {32'd1, 16'hBEEF}) begin n_err++; $display("FAIL proto_idle_pop: got %h want %h", {words_sent, bus.ep_datain}, {32'd1, 16'hBEEF}); end
        drive_cycle(1, 0, '0, 0, 0);
    endtask

    // Strobe and read in one cycle, then a mid-block restart strobe.
    task automatic test_back_to_back();
        push_random(256);
        drive_cycle(0, 0, '0, 0, 0);
        drive_cycle(0, 0, '0, 1, 1);
        n_cmp++; if ({fsm_state, proto_err, words_sent} !== {2'b10, 32'd1}) begin n_err++; $display("FAIL b2b_strobe_read: got %h want %h", {fsm_state, proto_err, words_sent}, {2'b10, 32'd1}); end
        host_reads(255);
        n_cmp++; if ({fsm_state, proto_err} !== 2'b00) begin n_err++; $display("FAIL b2b_block_end: got %b want 00", {fsm_state, proto_err}); end
        drive_cycle(0, 0, '0, 0, 0);
        drive_cycle(0, 0, '0, 0, 1);
        host_reads(10);
        drive_cycle(0, 0, '0, 0, 1);
        n_cmp++; if ({fsm_state, proto_err} !== 2'b11) begin n_err++; $display("FAIL b2b_restart: got %b want 11", {fsm_state, proto_err}); end
        host_reads(246);
        n_cmp++; if (fsm_state !== 1'b1) begin n_err++; $display("FAIL b2b_still_active: got %b want 1", fsm_state); end
        push_random(5);
        host_reads(10);
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL b2b_end: got %h want %h", dut_vec(), exp_vec()); end
        n_cmp++; if (fsm_state !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", fsm_state); end
        drive_cycle(1, 0, '0, 0, 0);
    endtask

    // Asynchronous reset partway through a block.
    task automatic test_reset_midblock();
        push_random(128);
        drive_cycle(0, 0, '0, 0, 0);
        drive_cycle(0, 0, '0, 0, 1);
        host_reads(100);
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_cmp++; if (dut_vec() !== {1'b1, 1'b0, 16'h0, 32'd0, 3'b000}) begin n_err++; $display("FAIL midblk_reset: got %h want %h", dut_vec(), {1'b1, 1'b0, 16'h0, 32'd0, 3'b000}); end
        #2;
        rst_n = 1'b1;
        drive_cycle(0, 0, '0, 0, 0);
        test_block("after_reset");
    endtask

    // Random MIG/host traffic, mostly well-behaved, with occasional
    // violations and flushes.
    task automatic test_random();
        logic rd;
        logic sb;
        for (int c = 0; c < 4000; c++) begin
            n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL rand[%0d]: got %h want %h", c, dut_vec(), exp_vec()); end
            sb = (m_ready && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
            rd = m_active ? 1'($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 99) == 0);
            drive_cycle(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)), $urandom, rd, sb);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.ep_read        = 1'b0;
        bus.ep_blockstrobe = 1'b0;
        m_reset();
        repeat (3) @(posedge ti_clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_block("block");
        test_threshold();
        test_full_wrap();
        test_underflow();
        test_proto();
        test_back_to_back();
        test_reset_midblock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
